uart_tx_feeder: RTL

Byte buffer and send sequencer that sits directly upstream of the UART transmitter. Accepts bytes from the data source (e.g. the dual-port RAM read side) on a write strobe, holds them in a 2^DEPTH_LOG2-entry FIFO, and issues one `send_en` pulse per byte with `data_byte` stable. After each pulse it waits for the transmitter's `tx_done` before presenting the next byte.

---
 rtl/uart_tx_feeder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding a UART transmitter: one send_en per byte, then wait for tx_done.
// Optional inter-byte gap state is compiled in with `define UART_TX_FEEDER_GAP_EN.
module uart_tx_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned GAP_CYCLES = 5208
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  tx_done,
  input  logic                  uart_state,
  output logic                  send_en,
  output logic [7:0]            data_byte,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fifo_cnt,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  if (GAP_CYCLES < 1) begin : g_gap_chk
    $error("uart_tx_feeder: GAP_CYCLES must be >= 1");
  end

`ifdef UART_TX_FEEDER_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
`endif

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             wr_acc_c;
  logic             pop_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // A byte leaves the FIFO only on the IDLE->SEND edge.
  always_comb begin
    wr_acc_c  = wr_en && !full;
    pop_c     = (state == S_IDLE) && !empty && !uart_state;
    cnt_nxt_c = fifo_cnt + CNT_W'(wr_acc_c) - CNT_W'(pop_c);
  end

  // Storage carries no reset; stale entries are never read because of fifo_cnt.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      state     <= S_IDLE;
      send_en   <= 1'b0;
      data_byte <= 8'h00;
      busy      <= 1'b0;
`ifdef UART_TX_FEEDER_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      fifo_cnt <= cnt_nxt_c;
      full     <= (cnt_nxt_c == CNT_W'(DEPTH));
      empty    <= (cnt_nxt_c == '0);
      overflow <= wr_en && full;
      if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);

      case (state)
        S_IDLE: begin
          send_en <= 1'b0;
          if (pop_c) begin
            data_byte <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_W'(1);
            send_en   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          send_en <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          send_en <= 1'b0;
          if (tx_done) begin
`ifdef UART_TX_FEEDER_GAP_EN
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            state   <= S_GAP;
`else
            busy    <= 1'b0;
            state   <= S_IDLE;
`endif
          end
        end
`ifdef UART_TX_FEEDER_GAP_EN
        S_GAP: begin
          send_en <= 1'b0;
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
`endif
        default: begin
          send_en <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
